// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator supervising PLL lock.
//
// Waits for pll_locked, debounces it, then releases a synchronous system
// reset. While running it produces N_CH single-cycle enable strobes. Each
// strobe has its own divide ratio and start phase, and both can be changed
// at runtime.
//
// Ports:
//   clk            system clock (PLL output)
//   rst_n          synchronous reset, active-low
//   pll_locked     PLL lock, already synchronised to clk
//   cfg_valid      config write request
//   cfg_ready      config write accept (always 1, no backpressure)
//   cfg_ch         target channel (values >= N_CH are accepted and dropped)
//   cfg_div        divide ratio (0 behaves as 1)
//   cfg_phase      start offset in cycles, taken mod divide ratio
//   ce             per-channel enable strobes (registered)
//   running        high while in RUN (registered)
//   sys_rst_n      downstream reset, released only in RUN (registered)
//   lock_loss_cnt  saturating count of RUN->WAIT_LOCK transitions
//                  (only present when CLK_EN_LOSS_CNT_EN is defined)
//
// Build option: define CLK_EN_LOSS_CNT_EN to add the lock_loss_cnt output.

// Per-channel divider. Holds the active div/phase, a shadow copy for writes
// made while running, and the down-counter that produces the strobe.
module clk_en_gen_ch #(
    parameter int DIV_W   = 16,
    parameter int RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_q,     // current cycle is RUN
    input  logic             run_d,     // next cycle is RUN
    input  logic             wr_en,     // accepted write addressed to this channel
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             ce
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d;
    logic [DIV_W-1:0] sphase_q, sphase_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;

    function automatic logic [DIV_W-1:0] eff(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    always_comb begin
        div_d    = div_q;
        phase_d  = phase_q;
        sdiv_d   = sdiv_q;
        sphase_d = sphase_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        if (run_q && run_d) begin
            // Steady RUN. A pending shadow takes effect at the reload, so
            // the period that is in progress always finishes unchanged.
            if (cnt_q == '0) begin
                if (pend_q) begin
                    div_d   = sdiv_q;
                    phase_d = sphase_q;
                    pend_d  = 1'b0;
                end
                cnt_d = eff(div_d) - DIV_W'(1);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
            if (wr_en) begin
                sdiv_d   = cfg_div;
                sphase_d = cfg_phase;
                pend_d   = 1'b1;
            end
        end else begin
            // Leaving RUN: commit any pending shadow so it is not lost. A
            // direct write on the same edge is newer and overrides it.
            if (run_q && pend_q) begin
                div_d   = sdiv_q;
                phase_d = sphase_q;
                pend_d  = 1'b0;
            end
            if (wr_en) begin
                div_d   = cfg_div;
                phase_d = cfg_phase;
            end
            // Entering RUN: the counter starts from the reduced phase, so
            // the first strobe comes 'phase' cycles after entry.
            if (run_d) begin
                cnt_d = phase_d % eff(div_d);
            end
        end
        ce_d = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= DIV_W'(RST_DIV);
            phase_q  <= '0;
            sdiv_q   <= '0;
            sphase_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            sdiv_q   <= sdiv_d;
            sphase_q <= sphase_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
        end
    end

    assign ce = ce_q;
endmodule

module clk_en_gen #(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int RST_DIV     = 1,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic [N_CH-1:0]  ce,
    output logic             running,
    output logic             sys_rst_n
`ifdef CLK_EN_LOSS_CNT_EN
   ,output logic [7:0]       lock_loss_cnt
`endif
);
    localparam int SC_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   settle_q, settle_d;
    logic              running_q, running_d;
    logic              sys_rst_n_q, sys_rst_n_d;
    logic [N_CH-1:0]   wr_en;
    logic              run_q, run_d;

    // The counter is cleared on the SETTLE entry edge and advances on each
    // locked edge. The RUN transition commits on the edge after it shows
    // LOCK_CYCLES, so RUN begins LOCK_CYCLES+1 edges after SETTLE entry.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!pll_locked) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SC_W'(LOCK_CYCLES)) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + SC_W'(1);
                end
            end
            RUN: begin
                if (!pll_locked) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
        // Outputs are taken from next state, so they move on the same edge as the FSM.
        running_d   = (state_d == RUN);
        sys_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            settle_q    <= '0;
            running_q   <= 1'b0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            running_q   <= running_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

    assign cfg_ready = 1'b1;
    assign running   = running_q;
    assign sys_rst_n = sys_rst_n_q;
    assign run_q     = (state_q == RUN);
    assign run_d     = (state_d == RUN);

    // Out-of-range channel numbers match no lane, so those writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        clk_en_gen_ch #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .run_q     (run_q),
            .run_d     (run_d),
            .wr_en     (wr_en[i]),
            .cfg_div   (cfg_div),
            .cfg_phase (cfg_phase),
            .ce        (ce[i])
        );
    end

`ifdef CLK_EN_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (run_q && !run_d && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) loss_cnt_q <= '0;
        else        loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    // Lock-loss counter not built.
`endif
endmodule
